video_window_compositor: RTL and testbench

- Parametrised successor to the post-scaler stage of the HDMI input path.
- Takes the scaled pixel stream (valid/ready, N channels) and the raw input raster timing (vs/hs/de). Places the scaled image as a window at a programmable (x, y) offset inside the full output raster.
- Pixels outside the window get a programmable background colour. Optional per-channel inversion.
- Sits between scaler_gray_top instances and the HDMI TX path. Replaces ad-hoc black-fill, delay-line panning and colour reversal with one block.

---
 rtl/video_pkg.sv | 25 ++
 rtl/video_fifo_sync.sv | 62 ++++++
 rtl/video_window_compositor.sv | 172 +++++++++++++++++
 tb/tb_video_window_compositor.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and helpers for the video window compositor: line FSM encoding,
// edge detection and pixel-width arithmetic.
package video_pkg;

  typedef enum logic [1:0] {
    LINE_IDLE  = 2'd0,
    LINE_LEFT  = 2'd1,
    LINE_WIN   = 2'd2,
    LINE_RIGHT = 2'd3
  } line_state_e;

  // Edges are taken against a 1-cycle registered copy of the same signal.
  function automatic logic rise_edge(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

  function automatic logic fall_edge(input logic cur, input logic prev);
    return ~cur & prev;
  endfunction

  function automatic int pix_width(input int channels, input int data_width);
    return channels * data_width;
  endfunction

endpackage

// File: rtl/video_fifo_sync.sv
// Single-clock pixel FIFO with registered read data, synchronous flush and
// extra-MSB pointers for full/empty discrimination.
module video_fifo_sync #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 2048
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic             do_wr, do_rd;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);

  // A flush wins over any same-cycle write or read.
  assign do_wr = wr_en_i & ~full_o & ~flush_i;
  assign do_rd = rd_en_i & ~empty_o & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    if (do_rd) rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/video_window_compositor.sv
// Places a scaled pixel stream as a window inside the input raster, filling the
// rest with a background colour; geometry is shadowed at each vsync rise.
module video_window_compositor
  import video_pkg::*;
#(
  parameter int CHANNELS   = 3,
  parameter int DATA_WIDTH = 8,
  parameter int H_ACT      = 640,
  parameter int V_ACT      = 720,
  parameter int CNT_WIDTH  = 12,
  parameter int FIFO_DEPTH = 2048,
  parameter int TIMING_LAT = 2
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      vs_i,
  input  logic                                      hs_i,
  input  logic                                      de_i,
  input  logic                                      s_tvalid_i,
  input  logic [pix_width(CHANNELS, DATA_WIDTH)-1:0] s_tdata_i,
  output logic                                      s_tready_o,
  input  logic [CNT_WIDTH-1:0]                      win_width_i,
  input  logic [CNT_WIDTH-1:0]                      win_height_i,
  input  logic [CNT_WIDTH-1:0]                      offset_x_i,
  input  logic [CNT_WIDTH-1:0]                      offset_y_i,
  input  logic [CHANNELS-1:0]                       invert_i,
  input  logic [pix_width(CHANNELS, DATA_WIDTH)-1:0] bg_color_i,
  output logic                                      vs_o,
  output logic                                      hs_o,
  output logic                                      de_o,
  output logic [pix_width(CHANNELS, DATA_WIDTH)-1:0] data_o,
  output logic                                      underflow_o,
  output logic                                      cfg_err_o
);

  localparam int                   PW     = pix_width(CHANNELS, DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] V_LAST = CNT_WIDTH'(V_ACT);
  localparam logic [CNT_WIDTH:0]   H_LIM  = (CNT_WIDTH+1)'(H_ACT);
  localparam logic [CNT_WIDTH:0]   V_LIM  = (CNT_WIDTH+1)'(V_ACT);

  function automatic logic [PW-1:0] apply_invert(input logic [PW-1:0] pix,
                                                 input logic [CHANNELS-1:0] mask);
    logic [PW-1:0] res;
    res = pix;
    for (int c = 0; c < CHANNELS; c++) begin
      if (mask[c]) res[(CHANNELS-c)*DATA_WIDTH-1 -: DATA_WIDTH] = ~pix[(CHANNELS-c)*DATA_WIDTH-1 -: DATA_WIDTH];
    end
    return res;
  endfunction

  logic [TIMING_LAT-1:0] vs_dl_q, hs_dl_q, de_dl_q;
  logic [CNT_WIDTH-1:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [CNT_WIDTH-1:0]  win_w_q, win_h_q, off_x_q, off_y_q;
  logic [CHANNELS-1:0]   inv_q;
  logic [PW-1:0]         bg_q;
  logic [PW-1:0]         data_q, data_d;
  logic [PW-1:0]         fifo_rd_data;
  logic                  fifo_full, fifo_empty;
  logic                  uf_q, cfg_err_q, pop_p1_q;
  logic                  fs, de_fall, cfg_ok, v_in, in_win, pop;
  logic [CNT_WIDTH:0]    x_end_req, y_end_req, y_end_sh;
  logic [CNT_WIDTH-1:0]  x_last;
  line_state_e           st_q, st_d, st_cur;

  assign fs      = rise_edge(vs_i, vs_dl_q[0]);
  assign de_fall = fall_edge(de_i, de_dl_q[0]);

  assign x_end_req = {1'b0, offset_x_i} + {1'b0, win_width_i};
  assign y_end_req = {1'b0, offset_y_i} + {1'b0, win_height_i};
  assign cfg_ok    = (win_width_i != '0) && (win_height_i != '0) &&
                     (x_end_req <= H_LIM) && (y_end_req <= V_LIM);

  assign y_end_sh = {1'b0, off_y_q} + {1'b0, win_h_q};
  assign x_last   = off_x_q + win_w_q - CNT_WIDTH'(1);
  assign v_in     = (v_cnt_q >= off_y_q) && ({1'b0, v_cnt_q} < y_end_sh);

  assign h_cnt_d = de_i ? h_cnt_q + CNT_WIDTH'(1) : '0;

  always_comb begin
    v_cnt_d = v_cnt_q;
    if (fs) v_cnt_d = '0;
    else if (de_fall && (v_cnt_q != V_LAST)) v_cnt_d = v_cnt_q + CNT_WIDTH'(1);
  end

  // st_cur is the state that applies to the pixel on the inputs this cycle.
  always_comb begin
    st_cur = LINE_IDLE;
    st_d   = LINE_IDLE;
    if (de_i) begin
      st_cur = (st_q == LINE_IDLE) ? LINE_LEFT : st_q;
      if ((st_cur == LINE_LEFT) && v_in && (h_cnt_q == off_x_q)) st_cur = LINE_WIN;
      st_d = st_cur;
      if ((st_cur == LINE_WIN) && (h_cnt_q == x_last)) st_d = LINE_RIGHT;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) st_q <= LINE_IDLE;
    else       st_q <= st_d;
  end

  assign in_win     = (st_cur == LINE_WIN);
  assign pop        = in_win & ~fifo_empty & ~fs;
  assign s_tready_o = ~fifo_full & ~rst_i;

  video_fifo_sync #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (fs),
    .wr_en_i   (s_tvalid_i & s_tready_o),
    .wr_data_i (s_tdata_i),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Stage p1 -> output: FIFO word is registered; choose pixel or background.
  always_comb begin
    data_d = '0;
    if (de_dl_q[0]) data_d = pop_p1_q ? apply_invert(fifo_rd_data, inv_q) : bg_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vs_dl_q   <= '0;
      hs_dl_q   <= '0;
      de_dl_q   <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      pop_p1_q  <= 1'b0;
      data_q    <= '0;
      uf_q      <= 1'b0;
      cfg_err_q <= 1'b0;
      win_w_q   <= '0;
      win_h_q   <= '0;
      off_x_q   <= '0;
      off_y_q   <= '0;
      inv_q     <= '0;
      bg_q      <= '0;
    end else begin
      vs_dl_q   <= {vs_dl_q[TIMING_LAT-2:0], vs_i};
      hs_dl_q   <= {hs_dl_q[TIMING_LAT-2:0], hs_i};
      de_dl_q   <= {de_dl_q[TIMING_LAT-2:0], de_i};
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      pop_p1_q  <= pop;
      data_q    <= data_d;
      uf_q      <= uf_q | (in_win & fifo_empty);
      cfg_err_q <= cfg_err_q | (fs & ~cfg_ok);
      if (fs && cfg_ok) begin
        win_w_q <= win_width_i;
        win_h_q <= win_height_i;
        off_x_q <= offset_x_i;
        off_y_q <= offset_y_i;
        inv_q   <= invert_i;
        bg_q    <= bg_color_i;
      end
    end
  end

  assign vs_o        = vs_dl_q[TIMING_LAT-1];
  assign hs_o        = hs_dl_q[TIMING_LAT-1];
  assign de_o        = de_dl_q[TIMING_LAT-1];
  assign data_o      = data_q;
  assign underflow_o = uf_q;
  assign cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_video_window_compositor.sv
// Bench for video_window_compositor on a 16x8 raster: table of frame configs,
// pixel scoreboard, plus FIFO-full and mid-frame reset sequences.
module tb_video_window_compositor;

  localparam int H = 16;
  localparam int V = 8;
  localparam int DEPTH = 16;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        vs_i = 1'b0, hs_i = 1'b0, de_i = 1'b0;
  logic        s_tvalid_i = 1'b0;
  logic [23:0] s_tdata_i = '0;
  logic        s_tready_o;
  logic [11:0] win_width_i = '0, win_height_i = '0, offset_x_i = '0, offset_y_i = '0;
  logic [2:0]  invert_i = '0;
  logic [23:0] bg_color_i = '0;
  logic        vs_o, hs_o, de_o;
  logic [23:0] data_o;
  logic        underflow_o, cfg_err_o;

  video_window_compositor #(
    .CHANNELS(3), .DATA_WIDTH(8), .H_ACT(H), .V_ACT(V),
    .CNT_WIDTH(12), .FIFO_DEPTH(DEPTH), .TIMING_LAT(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .vs_i(vs_i), .hs_i(hs_i), .de_i(de_i),
    .s_tvalid_i(s_tvalid_i), .s_tdata_i(s_tdata_i), .s_tready_o(s_tready_o),
    .win_width_i(win_width_i), .win_height_i(win_height_i),
    .offset_x_i(offset_x_i), .offset_y_i(offset_y_i),
    .invert_i(invert_i), .bg_color_i(bg_color_i),
    .vs_o(vs_o), .hs_o(hs_o), .de_o(de_o), .data_o(data_o),
    .underflow_o(underflow_o), .cfg_err_o(cfg_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          w, h, ox, oy;
    logic [2:0]  inv;
    logic [23:0] bg;
    int          npix;
    logic [23:0] pbase;
    logic        exp_cfg;
    logic        exp_uf;
  } frame_vec_t;

  frame_vec_t  tbl[7];
  int          n_vec = 0, n_err = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_px;
  bit          mon_en = 0, zero_chk = 0;
  logic [2:0]  h1 = '0, h2 = '0;
  int          m_w = 0, m_h = 0, m_ox = 0, m_oy = 0;
  logic [2:0]  m_inv = '0;
  logic [23:0] m_bg = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] inv_px(input logic [23:0] p, input logic [2:0] m);
    logic [7:0] ch [3];
    for (int c = 0; c < 3; c++) begin
      ch[c] = p[23-8*c -: 8];
      if (m[c]) ch[c] = 8'hFF - ch[c];
    end
    return {ch[0], ch[1], ch[2]};
  endfunction

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin
    if (mon_en) begin
      check("vs_o", 32'(vs_o), 32'(h2[2]));
      check("hs_o", 32'(hs_o), 32'(h2[1]));
      check("de_o", 32'(de_o), 32'(h2[0]));
      if (de_o) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL data_o_unexpected: got %06h with no expected pixel", data_o);
        end else begin
          exp_px = exp_q.pop_front();
          check("data_o", 32'(data_o), 32'(exp_px));
        end
      end else begin
        check("data_o_blank", 32'(data_o), 32'(0));
      end
    end
    if (zero_chk) check("data_o_after_rst", 32'(data_o), 32'(0));
    h2 = h1;
    h1 = {vs_i, hs_i, de_i};
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_vs_o"}, 32'(vs_o), 32'(0));
    check({tag, "_hs_o"}, 32'(hs_o), 32'(0));
    check({tag, "_de_o"}, 32'(de_o), 32'(0));
    check({tag, "_data_o"}, 32'(data_o), 32'(0));
    check({tag, "_tready"}, 32'(s_tready_o), 32'(0));
    check({tag, "_underflow"}, 32'(underflow_o), 32'(0));
    check({tag, "_cfg_err"}, 32'(cfg_err_o), 32'(0));
  endtask

  task automatic run_frame(input frame_vec_t fv, input int rst_line);
    int k;
    logic [23:0] e;
    bit inw;
    vs_i = 0; hs_i = 0; de_i = 0; s_tvalid_i = 0; rst_i = 0;
    repeat (3) cyc();
    mon_en = 1;
    win_width_i = 12'(fv.w); win_height_i = 12'(fv.h);
    offset_x_i = 12'(fv.ox); offset_y_i = 12'(fv.oy);
    invert_i = fv.inv; bg_color_i = fv.bg;
    vs_i = 1;
    cyc();
    if (fv.w >= 1 && fv.h >= 1 && fv.ox + fv.w <= H && fv.oy + fv.h <= V) begin
      m_w = fv.w; m_h = fv.h; m_ox = fv.ox; m_oy = fv.oy; m_inv = fv.inv; m_bg = fv.bg;
    end
    // Port values after the frame start must be ignored until the next one.
    win_width_i = 12'd1; win_height_i = 12'd1; offset_x_i = '0; offset_y_i = '0;
    invert_i = 3'b111; bg_color_i = 24'hAAAAAA;
    for (int p = 0; p < fv.npix; p++) begin
      s_tvalid_i = 1;
      s_tdata_i = fv.pbase + 24'(p);
      if (p >= 1) vs_i = 0;
      check("tready_prefill", 32'(s_tready_o), 32'(1));
      cyc();
    end
    s_tvalid_i = 0;
    vs_i = 0;
    k = 0;
    for (int v = 0; v < V; v++) begin
      for (int h = 0; h < H; h++) begin
        de_i = 1;
        rst_i = 0;
        if (v == rst_line && h == 2) begin
          rst_i = 1;
          mon_en = 0;
          #1;
          check_all_zero("rst_mid");
          exp_q.delete();
          zero_chk = 1;
          m_w = 0; m_h = 0; m_ox = 0; m_oy = 0; m_inv = '0; m_bg = '0;
        end
        if (mon_en) begin
          inw = (h >= m_ox) && (h < m_ox + m_w) && (v >= m_oy) && (v < m_oy + m_h);
          e = m_bg;
          if (inw) begin
            if (k < fv.npix) e = inv_px(fv.pbase + 24'(k), m_inv);
            k++;
          end
          exp_q.push_back(e);
        end
        cyc();
      end
      de_i = 0;
      rst_i = 0;
      for (int b = 0; b < 4; b++) begin
        hs_i = (b == 1);
        cyc();
      end
      hs_i = 0;
    end
    repeat (3) cyc();
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    zero_chk = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    tbl[0] = '{4, 2, 5, 3, 3'b000, 24'h102030, 8, 24'h000001, 1'b0, 1'b0};
    tbl[1] = '{4, 2, 5, 3, 3'b101, 24'h102030, 8, 24'h12AB34, 1'b0, 1'b0};
    tbl[2] = '{4, 2, 14, 3, 3'b000, 24'hFFFFFF, 8, 24'h000100, 1'b1, 1'b0};
    tbl[3] = '{4, 2, 5, 3, 3'b000, 24'h102030, 5, 24'h000001, 1'b1, 1'b1};
    tbl[4] = '{16, 1, 0, 0, 3'b000, 24'h00FF00, 16, 24'h000200, 1'b1, 1'b1};
    tbl[5] = '{4, 1, 12, 7, 3'b010, 24'h0000FF, 4, 24'h000300, 1'b1, 1'b1};
    tbl[6] = '{0, 1, 0, 0, 3'b000, 24'h000000, 4, 24'h000400, 1'b1, 1'b1};

    rst_i = 1;
    repeat (2) cyc();
    check_all_zero("reset");
    rst_i = 0;
    cyc();
    check("tready_after_rst", 32'(s_tready_o), 32'(1));

    for (int i = 0; i < 7; i++) begin
      run_frame(tbl[i], -1);
      check("cfg_err_o", 32'(cfg_err_o), 32'(tbl[i].exp_cfg));
      check("underflow_o", 32'(underflow_o), 32'(tbl[i].exp_uf));
    end

    // Fill the FIFO with no window active, then flush it with a frame start.
    vs_i = 0; de_i = 0; s_tvalid_i = 0;
    repeat (3) cyc();
    vs_i = 1;
    cyc();
    vs_i = 0;
    cyc();
    acc = 0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      s_tvalid_i = 1;
      s_tdata_i = 24'(i);
      check("tready_fill", 32'(s_tready_o), 32'(i < DEPTH));
      if (s_tready_o) acc++;
      cyc();
    end
    check("accepted_writes", 32'(acc), 32'(DEPTH));
    vs_i = 1;
    cyc();
    check("tready_after_fs", 32'(s_tready_o), 32'(1));
    s_tvalid_i = 0;
    vs_i = 0;
    cyc();

    run_frame(tbl[0], 3);
    run_frame(tbl[0], -1);
    check("cfg_err_post_rst", 32'(cfg_err_o), 32'(0));
    check("underflow_post_rst", 32'(underflow_o), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
